mio_bus_arbiter: RTL

- Two-master arbiter and sequencer in front of the MIO bus decoder. It shares one address/data/write path between master 0 (the CPU) and master 1 (a DMA or copy engine, e.g. keyboard to VRAM).
- It serialises accesses into fixed-length bus transactions: grant, drive the bus, wait, capture read data, acknowledge.
- All bus-side outputs are registered, so the decoder sees a stable address for the whole transaction.

---
 rtl/mio_bus_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: two-master arbiter/sequencer in front of the MIO bus decoder.
// Each access becomes a fixed-length transaction: IDLE (arbitrate), ACCESS for
// WAIT_CYCLES cycles (address held, single write strobe), RESP (one ack pulse).
// Every bus-side output comes straight from a register.
module mio_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,    // legal range 1..15
    parameter bit          FIXED_PRIO  = 1'b0  // 0: round-robin on ties, 1: master 0 wins ties
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_last;       // master that owned the most recent completed transaction
    logic        r_we;         // latched direction, kept after the strobe drops
    logic [1:0]  r_grant;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_bus_we;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_req_any;
    logic        w_pick_m1;
    logic        w_cnt_done;
    logic        w_owner_m1;

    assign w_req_any  = m0_req | m1_req;
    // Master 1 wins if it is the only requester, or on a round-robin tie when master 0 went last.
    assign w_pick_m1  = m1_req & (~m0_req | ((FIXED_PRIO == 1'b0) & ~r_last));
    assign w_cnt_done = (r_cnt == 4'(WAIT_CYCLES - 1));
    assign w_owner_m1 = r_grant[1];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold ACCESS for WAIT_CYCLES cycles, one RESP cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_req_any) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_cnt_done) w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch the winner's request, sequence the strobe, capture read data, pulse ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_grant    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_bus_we   <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_grant  <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_addr   <= w_pick_m1 ? m1_addr  : m0_addr;
                        r_wdata  <= w_pick_m1 ? m1_wdata : m0_wdata;
                        r_we     <= w_pick_m1 ? m1_we    : m0_we;
                        r_bus_we <= w_pick_m1 ? m1_we    : m0_we;
                        r_cnt    <= '0;
                    end
                end
                ST_ACCESS: begin
                    r_bus_we <= 1'b0;
                    r_cnt    <= r_cnt + 4'd1;
                    if (w_cnt_done) begin
                        if (!r_we) begin
                            if (w_owner_m1) r_m1_rdata <= bus_rdata;
                            else            r_m0_rdata <= bus_rdata;
                        end
                        r_addr   <= '0;
                        r_wdata  <= '0;
                        r_m0_ack <= ~w_owner_m1;
                        r_m1_ack <= w_owner_m1;
                    end
                end
                ST_RESP: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_grant  <= '0;
                    r_last   <= w_owner_m1;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_we    = r_bus_we;
    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule
